data_break_arbiter: RTL
=======================

DATA_BREAK_ARBITER -- requirements
Module: data_break_arbiter

Interface
REQ-001 Parameter NCHAN, default 2: number of data-break channels, legal range 1..8.
REQ-002 Parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with channel 0 highest.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles in WAIT_DB0 before the transfer is abandoned.
REQ-004 clk  in  1  single clock for the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clear  in  1  synchronous clear (CAF), active-high.
REQ-007 state  in  5  CPU major state, using the DB0/DB1/DB2 encodings.
REQ-008 req  in  NCHAN  per-channel data-break request, level.
REQ-009 wr  in  NCHAN  per-channel direction: 1 = write to memory, 0 = read from memory.
REQ-010 addr  in  NCHAN*15  per-channel {field[0:2], address[0:11]}; channel i occupies slice i.
REQ-011 wdata  in  NCHAN*12  per-channel write data; channel i occupies slice i.
REQ-012 ack  out  NCHAN  one-cycle completion pulse to the granted channel.
REQ-013 err  out  1  one-cycle pulse coincident with ack when the transfer timed out.
REQ-014 rdata  out  12  read data, valid in the ack cycle.
REQ-015 db_read  out  1  data-break read request to the CPU state machine.
REQ-016 db_write  out  1  data-break write request to the CPU state machine.
REQ-017 mem_addr  out  15  latched {field, address} of the granted transfer.
REQ-018 mem_wdata  out  12  latched write data of the granted transfer.
REQ-019 mem_rdata  in  12  memory read data, valid when state == DB2.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have exactly five states: IDLE, WAIT_DB0, WAIT_DB2, DONE, HOLD.
- IDLE: on any req bit high, latch the winner's index, wr, addr and wdata; next state WAIT_DB0.
- WAIT_DB0: db_read = ~wr_latched and db_write = wr_latched, both registered.
  - On state == DB0, next state WAIT_DB2 and both requests drop at that edge.
  - Otherwise, if the cycle counter reaches TIMEOUT, next state DONE with the error flag set.
- WAIT_DB2: on state == DB2, capture mem_rdata into rdata when this is a read; next state DONE.
- DONE: ack[grant] = 1, plus err if flagged; next state HOLD.
- HOLD: one idle cycle so the channel can drop req; next state IDLE.
REQ-022 Fixed-priority mode SHALL grant the lowest-index asserted req.
REQ-023 Round-robin mode SHALL search upward from the pointer with wrap-around.
- The pointer becomes (grant+1) mod NCHAN in DONE.
- With NCHAN = 1, the pointer is constant 0.
REQ-024 Latency from req sampled high in IDLE to db_read/db_write high SHALL be 1 cycle.
REQ-025 A channel SHALL hold req, wr, addr and wdata stable until ack, and SHALL deassert req at the edge that samples ack.
REQ-026 Requests arriving while busy SHALL wait, with no loss and no queue beyond the req level.
REQ-027 A channel whose req falls before grant SHALL simply not be granted.
REQ-028 mem_addr and mem_wdata SHALL stay constant from IDLE exit until HOLD exit.
REQ-029 rdata SHALL hold its last value when no read is completed; on a write ack it is unchanged.
REQ-030 The timeout counter SHALL be 8 bits minimum, cleared on IDLE exit, and SHALL saturate rather than wrap.
REQ-031 state == DB2 seen in WAIT_DB0 SHALL be ignored; a DB0 is required first.
REQ-032 clear SHALL force IDLE and zero all outputs except rdata at the next edge.
- A transfer in progress is abandoned without ack.
- The RR pointer is reset to 0.

Reset
REQ-033 reset SHALL asynchronously force the following, independent of clk, including mid-transfer:
- IDLE state;
- ack, err, db_read, db_write and busy = 0;
- rdata, mem_addr and mem_wdata = 0;
- RR pointer and timeout counter = 0.

Structure
REQ-034 The DB0/DB1/DB2 encodings and the arbiter state encodings SHALL live in the shared parameters include.
REQ-035 Winner selection SHALL be a sub-module db_pick with parameters NCHAN and RR.
- Inputs: req and pointer.
- Outputs: grant index and any-flag.
- It is purely combinational.

Verification
REQ-036 Single write: NCHAN=2, ch1 wr=1, addr=15'o10200, wdata=12'o1234. db_write SHALL rise 1 cycle later; after DB0 then DB2, ack=2'b10 for 1 cycle, mem_addr=15'o10200, mem_wdata=12'o1234.
REQ-037 Single read: ch0 read, mem_rdata=12'o7777 at DB2. ack[0] SHALL pulse with rdata=12'o7777.
REQ-038 Round-robin: ch0 and ch1 req simultaneously, held, for 4 transfers with RR=1. Grants SHALL be 0,1,0,1; with RR=0 they SHALL be 0,0,0,0 while ch0 stays asserted.
REQ-039 Timeout: TIMEOUT=10 and state never reaches DB0. ack and err SHALL pulse together exactly 10 cycles after WAIT_DB0 entry, and db_* SHALL be low afterwards.
REQ-040 Asynchronous reset in WAIT_DB2 with the clock stopped: busy, db_write and ack SHALL go 0 immediately; after release, a new req SHALL be granted normally.

Source files
------------

// File: rtl/data_break_arbiter_pkg.sv
// Shared encodings for the data-break arbiter: CPU major-state codes for the
// data-break cycles, arbiter FSM states and an index-width helper.
package data_break_arbiter_pkg;

  localparam logic [4:0] DB0 = 5'h10;
  localparam logic [4:0] DB1 = 5'h11;
  localparam logic [4:0] DB2 = 5'h12;

  localparam int AW = 15;
  localparam int DW = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DB0 = 3'd1,
    ST_WAIT_DB2 = 3'd2,
    ST_DONE     = 3'd3,
    ST_HOLD     = 3'd4
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_break_arbiter_db_pick.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin searching upward from i_ptr with wrap-around.
module db_pick
  import data_break_arbiter_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int RR    = 1
) (
  input  logic [NCHAN-1:0]        i_req,
  input  logic [idx_w(NCHAN)-1:0] i_ptr,
  output logic [idx_w(NCHAN)-1:0] o_grant,
  output logic                    o_any
);

  localparam int IW = idx_w(NCHAN);

  // First pass covers channels at or above the pointer, second pass wraps.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!o_any && i_req[i] && ((RR == 0) || (IW'(i) >= i_ptr))) begin
        o_grant = IW'(i);
        o_any   = 1'b1;
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (!o_any && i_req[i]) begin
        o_grant = IW'(i);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_break_arbiter.sv
// Data-break arbiter: picks one of NCHAN channels, requests a DB cycle from the
// CPU state machine, waits for DB0/DB2 (with timeout) and acks the channel.
module data_break_arbiter
  import data_break_arbiter_pkg::*;
#(
  parameter int NCHAN   = 2,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic [4:0]          i_state,
  input  logic [NCHAN-1:0]    i_req,
  input  logic [NCHAN-1:0]    i_wr,
  input  logic [NCHAN*15-1:0] i_addr,
  input  logic [NCHAN*12-1:0] i_wdata,
  output logic [NCHAN-1:0]    o_ack,
  output logic                o_err,
  output logic [11:0]         o_rdata,
  output logic                o_db_read,
  output logic                o_db_write,
  output logic [14:0]         o_mem_addr,
  output logic [11:0]         o_mem_wdata,
  input  logic [11:0]         i_mem_rdata,
  output logic                o_busy
);

  localparam int IW = idx_w(NCHAN);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [IW-1:0] LAST_CH = IW'(NCHAN - 1);

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_ptr;
  logic            r_wr;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            r_db_read;
  logic            r_db_write;
  logic [DW-1:0]   r_rdata;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;

  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic            w_sel_wr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_timeout;
  logic [IW-1:0]   w_ptr_next;

  db_pick #(.NCHAN(NCHAN), .RR(RR)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (w_pick == IW'(i)) begin
        w_sel_wr    = i_wr[i];
        w_sel_addr  = i_addr[i*15 +: 15];
        w_sel_wdata = i_wdata[i*12 +: 12];
      end
    end
  end

  // Saturating count of cycles spent in WAIT_DB0.
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_inc >= CW'(TIMEOUT));
  assign w_ptr_next = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_any) w_next = ST_WAIT_DB0;
      ST_WAIT_DB0: begin
        if (i_state == DB0)  w_next = ST_WAIT_DB2;
        else if (w_timeout)  w_next = ST_DONE;
      end
      ST_WAIT_DB2: if (i_state == DB2) w_next = ST_DONE;
      ST_DONE:     w_next = ST_HOLD;
      ST_HOLD:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
    if (i_clear) w_next = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant     <= '0;
      r_ptr       <= '0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_db_read   <= 1'b0;
      r_db_write  <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (i_clear) begin
      r_grant     <= '0;
      r_ptr       <= '0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_db_read   <= 1'b0;
      r_db_write  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_wr        <= w_sel_wr;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_db_read   <= ~w_sel_wr;
            r_db_write  <= w_sel_wr;
          end
        end
        ST_WAIT_DB0: begin
          if (i_state == DB0) begin
            r_db_read  <= 1'b0;
            r_db_write <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_err      <= 1'b1;
              r_db_read  <= 1'b0;
              r_db_write <= 1'b0;
            end
          end
        end
        ST_WAIT_DB2: begin
          if ((i_state == DB2) && !r_wr) r_rdata <= i_mem_rdata;
        end
        ST_DONE: r_ptr <= w_ptr_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ack = '0;
    for (int i = 0; i < NCHAN; i++) begin
      o_ack[i] = (r_state == ST_DONE) && (r_grant == IW'(i));
    end
  end

  assign o_err       = (r_state == ST_DONE) && r_err;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_db_read   = r_db_read;
  assign o_db_write  = r_db_write;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
